serial_parity_framer: RTL

Frame controller that sequences a serial-parity datapath. Accepts a parallel word over a valid/ready handshake and shifts it out one bit per accepted cycle. Keeps a running XOR over the transmitted bits, with the same per-bit behaviour as the serial parity unit, and appends the parity bit as the final frame slot. Sits between a word-level producer and a bit-serial link or checker, and gates the serial stream with a ready/valid handshake.

---
 rtl/serial_parity_framer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_parity_framer.sv
// rtl/serial_parity_framer.sv - word-to-serial framer that appends a running parity slot.
// Build option SERIAL_PARITY_ODD_EN selects odd parity for the parity slot and p.
module serial_parity_framer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             x,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             x_is_parity,
  output logic             p,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             p_q, p_d;
  logic             frame_done_q, frame_done_d;
  logic             out_bit;
  logic             par_bit;

  assign out_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

`ifdef SERIAL_PARITY_ODD_EN
  assign par_bit = ~acc_q;
`else
  assign par_bit = acc_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      p_q          <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      p_q          <= p_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (x_ready && (cnt_q == CNT_LAST)) state_d = PARITY;
      PARITY:  if (x_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything holds unless a slot is handed off; frame_done is a single-cycle pulse.
  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    p_d          = p_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d  = in_data;
          cnt_d = '0;
          acc_d = 1'b0;
        end
      end
      SHIFT: begin
        if (x_ready) begin
          acc_d = acc_q ^ out_bit;
          sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (x_ready) begin
          p_d          = par_bit;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        frame_done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    x_valid     = 1'b0;
    x           = 1'b0;
    x_is_parity = 1'b0;
    case (state_q)
      IDLE:   in_ready = 1'b1;
      SHIFT: begin
        x_valid = 1'b1;
        x       = out_bit;
      end
      PARITY: begin
        x_valid     = 1'b1;
        x           = par_bit;
        x_is_parity = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign p          = p_q;
  assign frame_done = frame_done_q;

endmodule
